// File: rtl/key_event_scheduler.sv
// Key event scheduler: FIFO-buffers key events and offers each one to the
// enabled PS/2 and HID sinks, retiring it once all have accepted or a timeout expires.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a buffered event and at least one enabled sink
//   ST_LOAD   | copy FIFO head to both sinks, latch pending bits, clear timer
//   ST_SEND   | handshaking with pending sinks, timer running
//   ST_RETIRE | pop the head entry
module key_event_scheduler #(
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3,
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       key_event,
    input  logic             on_event,
    input  logic             ps2_en,
    input  logic             hid_en,
    output logic [7:0]       ps2_data,
    output logic             ps2_valid,
    input  logic             ps2_ready,
    output logic [7:0]       hid_data,
    output logic             hid_valid,
    input  logic             hid_ready,
    input  logic             clear_status,
    output logic [PTR_W:0]   fifo_count,
    output logic             overflow,
    output logic             timeout_ps2,
    output logic             timeout_hid,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
    localparam logic [1:0] ST_RETIRE = 2'd3;

    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [TO_W-1:0]  TO_ONE   = 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic             pend_ps2_q, pend_ps2_d;
    logic             pend_hid_q, pend_hid_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic [7:0]       ps2_data_q, ps2_data_d;
    logic [7:0]       hid_data_q, hid_data_d;
    logic             overflow_q, overflow_d;
    logic             to_ps2_q, to_ps2_d;
    logic             to_hid_q, to_hid_d;

    logic pop;
    logic push_ok;
    logic keep_ps2;
    logic keep_hid;
    logic set_to_ps2;
    logic set_to_hid;

    // A pop at the same edge frees a slot, so a full FIFO can still accept.
    always_comb begin
        pop     = (state_q == ST_RETIRE);
        push_ok = on_event && ((count_q != CNT_FULL) || pop);

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = key_event;
        end
        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // A sink stays pending only if it did not accept and is still enabled.
    always_comb begin
        keep_ps2   = pend_ps2_q && !ps2_ready && ps2_en;
        keep_hid   = pend_hid_q && !hid_ready && hid_en;
        state_d    = state_q;
        pend_ps2_d = pend_ps2_q;
        pend_hid_d = pend_hid_q;
        timer_d    = timer_q;
        ps2_data_d = ps2_data_q;
        hid_data_d = hid_data_q;
        set_to_ps2 = 1'b0;
        set_to_hid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && (ps2_en || hid_en)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ps2_data_d = mem_q[rd_ptr_q];
                hid_data_d = mem_q[rd_ptr_q];
                pend_ps2_d = ps2_en;
                pend_hid_d = hid_en;
                timer_d    = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                timer_d    = timer_q + TO_ONE;
                pend_ps2_d = keep_ps2;
                pend_hid_d = keep_hid;
                if (timer_q == TO_LAST) begin
                    set_to_ps2 = keep_ps2;
                    set_to_hid = keep_hid;
                    pend_ps2_d = 1'b0;
                    pend_hid_d = 1'b0;
                    state_d    = ST_RETIRE;
                end else if (!keep_ps2 && !keep_hid) begin
                    state_d = ST_RETIRE;
                end
            end
            default: begin
                pend_ps2_d = 1'b0;
                pend_hid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        overflow_d = (overflow_q && !clear_status) || (on_event && !push_ok);
        to_ps2_d   = (to_ps2_q && !clear_status) || set_to_ps2;
        to_hid_d   = (to_hid_q && !clear_status) || set_to_hid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            pend_ps2_q <= 1'b0;
            pend_hid_q <= 1'b0;
            timer_q    <= '0;
            ps2_data_q <= '0;
            hid_data_q <= '0;
            overflow_q <= 1'b0;
            to_ps2_q   <= 1'b0;
            to_hid_q   <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            pend_ps2_q <= pend_ps2_d;
            pend_hid_q <= pend_hid_d;
            timer_q    <= timer_d;
            ps2_data_q <= ps2_data_d;
            hid_data_q <= hid_data_d;
            overflow_q <= overflow_d;
            to_ps2_q   <= to_ps2_d;
            to_hid_q   <= to_hid_d;
        end
    end

    assign ps2_data    = ps2_data_q;
    assign hid_data    = hid_data_q;
    assign ps2_valid   = (state_q == ST_SEND) && pend_ps2_q;
    assign hid_valid   = (state_q == ST_SEND) && pend_hid_q;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign timeout_ps2 = to_ps2_q;
    assign timeout_hid = to_hid_q;
    assign busy        = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Buffers key events from keyboard_send and shares each event between the two host output paths, keyboard_ps2 and keyboard_hid.
- Each event is presented to every enabled sink with a valid/ready handshake. The event retires only when all enabled sinks have accepted it, or the timeout expires.
- Sits between keyboard_send and the two protocol blocks in top, all on CLK_50.

Parameters:
DEPTH, 8, event FIFO entries (power of 2)
PTR_W, 3, log2(DEPTH)
TIMEOUT, 50000, max SEND cycles per event (1 ms at 50 MHz)
TO_W, 16, timeout counter width

Ports:
clock  in  1  system clock (CLK_50)
reset  in  1  synchronous, active-high
key_event  in  8  event code from keyboard_send, opaque
on_event  in  1  1-cycle write strobe for key_event
ps2_en  in  1  PS/2 sink enabled
hid_en  in  1  HID sink enabled
ps2_data  out  8  event to PS/2 sink
ps2_valid  out  1  ps2_data valid
ps2_ready  in  1  PS/2 sink accepts
hid_data  out  8  event to HID sink
hid_valid  out  1  hid_data valid
hid_ready  in  1  HID sink accepts
clear_status  in  1  pulse, clears sticky flags
fifo_count  out  PTR_W+1  entries held
overflow  out  1  sticky, event dropped on full
timeout_ps2  out  1  sticky, PS/2 sink timed out
timeout_hid  out  1  sticky, HID sink timed out
busy  out  1  state!=IDLE or fifo_count!=0

Behaviour:
- Reset, synchronous, active-high:
  - FIFO flushed, pointers 0, fifo_count 0.
  - ps2_valid and hid_valid low, data outputs 0.
  - All sticky flags 0, FSM in IDLE, timer 0.
  - Reset mid-handshake aborts without retiring; the in-flight event is lost.
- Push: on_event high at an edge writes key_event.
  - Accepted if fifo_count<DEPTH, or if a pop occurs at the same edge.
  - Otherwise the event is dropped and overflow is set.
- Simultaneous push and pop: fifo_count unchanged. Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if fifo_count>0 and (ps2_en|hid_en), go to LOAD. If both sinks are disabled, events are held, not discarded.
  - LOAD:
    - Head is copied to ps2_data and hid_data.
    - pend_ps2 set to ps2_en, pend_hid set to hid_en.
    - Timer cleared; go to SEND.
  - SEND:
    - x_valid equals pend_x. Data is held stable while valid.
    - x_valid&x_ready at an edge clears pend_x, so valid drops in the next cycle. Both sinks may accept at the same edge.
    - Sink disabled while pending: pend_x cleared at the next edge, no timeout flag.
    - Both pend bits clear: go to RETIRE.
    - Timer increments each SEND cycle. At timer==TIMEOUT-1 with any pend set: set timeout_x for each pending sink, clear pend bits, go to RETIRE.
    - Acceptance at the timeout edge counts as accepted, with no flag for that sink.
  - RETIRE: pop head, go to IDLE.
- Latency: with FIFO empty and FSM in IDLE, on_event high in cycle 0 gives valid high in cycle 3.
- Throughput: with immediate ready, one event per 4 cycles (IDLE, LOAD, SEND, RETIRE).
- Sticky flags are cleared by clear_status. If set and clear occur at the same edge, set wins.
- Event order is strictly FIFO. Each event is offered exactly once per enabled sink.

Test Plan:
- Single event, both sinks enabled, ready tied high: on_event with 0x85 in cycle 0 gives both valids high in cycle 3 with data 0x85. fifo_count returns to 0 by cycle 5, busy low afterwards.
- Skewed sinks: ps2_ready high immediately, hid_ready delayed 10 cycles.
  - ps2_valid drops after 1 cycle.
  - hid_valid is held with 0x85 for 10 cycles.
  - Pop only after the HID accept.
  - The next event 0x05 then appears on both sinks.
- Overflow: hid_ready low, push 10 events 0x01..0x0A.
  - fifo_count saturates at 8 and overflow=1.
  - After releasing ready, sinks receive 0x01..0x08 in order.
  - clear_status clears overflow.
- Timeout: TIMEOUT=100, ps2_ready never asserted, hid_ready high.
  - HID accepts at once; ps2_valid stays high 100 cycles, then drops.
  - timeout_ps2=1 and timeout_hid=0; the event is retired.
- Enable control:
  - Both enables low: 3 events pushed are held, valids stay low, fifo_count=3.
  - Raising hid_en alone delivers the 3 events only on HID; ps2_valid never rises.
  - Dropping hid_en mid-SEND retires the event without a timeout flag.
- Reset mid-operation: reset for 1 cycle during SEND with fifo_count=4.
  - Next cycle: valids 0, fifo_count 0, flags 0.
  - A subsequent event is delivered normally with 3-cycle latency.
